// File: rtl/db_tile_scheduler.sv
// ---------------------------------------------------------------------------
// db_tile_scheduler
//
// Ping-pong sequencer for a double-buffered memory core in tile mode. A tile
// of cfg_depth words is written into the fill bank while the drain bank is
// read cfg_reads times. Banks swap only after both sides have finished, so
// the core never sees a write into a bank that is still being read.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   clk_en             global enable; 0 freezes all state and gates strobes
//   flush              synchronous abort to IDLE (keeps tiles_done/cfg_err)
//   start              pulse in IDLE: capture cfg_depth/cfg_reads and begin
//   cfg_depth          words written per tile
//   cfg_reads          reads issued per tile
//   in_valid/in_ready  producer handshake; a word moves when both are 1
//   out_ready          downstream can take a read this cycle
//   wen_out, ren_out   write / read strobes to the core
//   switch_db          one-cycle bank swap strobe to the core
//   bank_sel           current fill bank
//   busy               scheduler is not IDLE
//   cfg_err            sticky flag for a start with zero depth or zero reads
//   tiles_done         number of fully drained tiles (wraps)
// ---------------------------------------------------------------------------
module db_tile_scheduler #(
  parameter int DEPTH_W = 16,
  parameter int READS_W = 32,
  parameter int TILE_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               flush,
  input  logic               start,
  input  logic [DEPTH_W-1:0] cfg_depth,
  input  logic [READS_W-1:0] cfg_reads,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               out_ready,
  output logic               wen_out,
  output logic               ren_out,
  output logic               switch_db,
  output logic               bank_sel,
  output logic               busy,
  output logic               cfg_err,
  output logic [TILE_W-1:0]  tiles_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIME  = 3'd1,
    RUN    = 3'd2,
    HOLD_W = 3'd3,
    HOLD_R = 3'd4,
    SWITCH = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [DEPTH_W-1:0] depth_q;
  logic [READS_W-1:0] reads_q;
  logic [DEPTH_W-1:0] wcnt;
  logic [READS_W-1:0] rcnt;

  // Set while the first tile of a run is being primed; the SWITCH that ends
  // it closes a tile that was never drained, so it must not count.
  logic               first_tile;

  logic               go;
  logic               cfg_ok;
  logic               accept_start;
  logic               reject_start;
  logic               wr_phase;
  logic               rd_phase;
  logic               last_wr;
  logic               last_rd;

  // -------------------------------------------------------------------------
  // Next-state and strobe decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    go           = clk_en & ~flush;
    cfg_ok       = (cfg_depth != '0) && (cfg_reads != '0);
    accept_start = go & start & (state == IDLE) & cfg_ok;
    reject_start = go & start & (state == IDLE) & ~cfg_ok;
    wr_phase     = (state == PRIME) || (state == RUN) || (state == HOLD_R);
    rd_phase     = (state == RUN) || (state == HOLD_W);

    // Limits are enforced here: a counter at its target masks the strobe.
    in_ready     = go & wr_phase & (wcnt < depth_q);
    wen_out      = in_valid & in_ready;
    ren_out      = go & rd_phase & (rcnt < reads_q) & out_ready;
    last_wr      = wen_out & (wcnt == depth_q - DEPTH_W'(1));
    last_rd      = ren_out & (rcnt == reads_q - READS_W'(1));

    switch_db    = go & (state == SWITCH);
    busy         = (state != IDLE);

    if (clk_en && flush) begin
      state_nxt = IDLE;
    end else if (clk_en) begin
      unique case (state)
        IDLE:    if (accept_start) state_nxt = PRIME;
        PRIME:   if (last_wr)      state_nxt = SWITCH;
        RUN: begin
          if (last_wr && last_rd) state_nxt = SWITCH;
          else if (last_wr)       state_nxt = HOLD_W;
          else if (last_rd)       state_nxt = HOLD_R;
        end
        HOLD_W:  if (last_rd)      state_nxt = SWITCH;
        HOLD_R:  if (last_wr)      state_nxt = SWITCH;
        SWITCH:                    state_nxt = RUN;
        default:                   state_nxt = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Counters, bank select and status flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt       <= '0;
      rcnt       <= '0;
      bank_sel   <= 1'b0;
      tiles_done <= '0;
      cfg_err    <= 1'b0;
      first_tile <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        wcnt       <= '0;
        rcnt       <= '0;
        bank_sel   <= 1'b0;
        first_tile <= 1'b0;
      end else if (state == SWITCH) begin
        wcnt       <= '0;
        rcnt       <= '0;
        bank_sel   <= ~bank_sel;
        first_tile <= 1'b0;
        if (!first_tile) tiles_done <= tiles_done + TILE_W'(1);
      end else begin
        if (accept_start) begin
          cfg_err    <= 1'b0;
          first_tile <= 1'b1;
          wcnt       <= '0;
          rcnt       <= '0;
        end
        if (reject_start) cfg_err <= 1'b1;
        if (wen_out)      wcnt    <= wcnt + DEPTH_W'(1);
        if (ren_out)      rcnt    <= rcnt + READS_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Tile configuration, captured on an accepted start (datapath, no reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept_start) begin
      depth_q <= cfg_depth;
      reads_q <= cfg_reads;
    end
  end

endmodule

// File: tb/tb_db_tile_scheduler.sv
// ---------------------------------------------------------------------------
// tb_db_tile_scheduler
//
// Self-checking bench for db_tile_scheduler: a per-cycle vector table for a
// small tile (depth=2, reads=3) plus hand-written multi-cycle sequences for
// streaming, clock-enable stretching, read back-pressure, flush, reset and
// configuration errors.
// ---------------------------------------------------------------------------
module tb_db_tile_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        flush;
  logic        start;
  logic [15:0] cfg_depth;
  logic [31:0] cfg_reads;
  logic        in_valid;
  logic        in_ready;
  logic        out_ready;
  logic        wen_out;
  logic        ren_out;
  logic        switch_db;
  logic        bank_sel;
  logic        busy;
  logic        cfg_err;
  logic [15:0] tiles_done;

  int n_tests = 0;
  int n_fail  = 0;

  db_tile_scheduler #(.DEPTH_W(16), .READS_W(32), .TILE_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .flush      (flush),
    .start      (start),
    .cfg_depth  (cfg_depth),
    .cfg_reads  (cfg_reads),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .wen_out    (wen_out),
    .ren_out    (ren_out),
    .switch_db  (switch_db),
    .bank_sel   (bank_sel),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .tiles_done (tiles_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, fl, st, iv, ordy;
    logic ir, wen, ren, sw, bank, bsy, err;
    int   tiles;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic [4:0] in_b, input logic [6:0] ex_b, input int t);
    vec_t v;
    {v.en, v.fl, v.st, v.iv, v.ordy}          = in_b;
    {v.ir, v.wen, v.ren, v.sw, v.bank, v.bsy, v.err} = ex_b;
    v.tiles = t;
    return v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 3 units later, well clear of both clock edges.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    clk_en    = 1'b0;
    flush     = 1'b0;
    start     = 1'b0;
    cfg_depth = '0;
    cfg_reads = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Streaming tile with depth=4, reads=16. With stretch=2 clk_en runs
  // 1,0,1,0 and every event lands at twice the distance from the start.
  task automatic scen_basic(input int stretch);
    int sw_cyc[$];
    int wen_pre, ren_pre, wen_mid, ren_mid, strobe_off;
    int s0, s1;
    string tag;
    tag = $sformatf("basic_x%0d", stretch);
    wen_pre = 0; ren_pre = 0; wen_mid = 0; ren_mid = 0; strobe_off = 0;
    do_reset();
    cfg_depth = 16'd4; cfg_reads = 32'd16; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 24 * stretch + 1; c++) begin
      clk_en = ((c - 1) % stretch == 0);
      start  = (c == 1);
      #3;
      if (!clk_en && (wen_out || ren_out || switch_db)) strobe_off++;
      if (sw_cyc.size() == 0) begin
        wen_pre += int'(wen_out);
        ren_pre += int'(ren_out);
      end else if (sw_cyc.size() == 1) begin
        wen_mid += int'(wen_out);
        ren_mid += int'(ren_out);
      end
      if (switch_db) sw_cyc.push_back(c);
      next_cycle();
    end
    start = 1'b0;
    s0 = (sw_cyc.size() > 0) ? sw_cyc[0] : -1;
    s1 = (sw_cyc.size() > 1) ? sw_cyc[1] : -1;
    chk({tag, ".n_switch"},   sw_cyc.size(), 2);
    chk({tag, ".switch1_cyc"}, s0, 1 + 5 * stretch);
    chk({tag, ".switch2_cyc"}, s1, 1 + 22 * stretch);
    chk({tag, ".wen_prime"},  wen_pre, 4);
    chk({tag, ".ren_prime"},  ren_pre, 0);
    chk({tag, ".wen_tile"},   wen_mid, 4);
    chk({tag, ".ren_tile"},   ren_mid, 16);
    chk({tag, ".strobe_en0"}, strobe_off, 0);
    chk({tag, ".tiles_done"}, tiles_done, 1);
    chk({tag, ".bank_sel"},   bank_sel, 0);
  endtask

  initial begin
    int sw_cyc[$];
    int sw_bank[$];
    int exp_cyc[4];
    int exp_bank[4];
    int wen_mid, ren_mid, ir_hold, ir_idle, s;

    // ---------------- reset state ----------------
    do_reset();
    #3;
    chk("rst.in_ready",   in_ready, 0);
    chk("rst.wen",        wen_out, 0);
    chk("rst.ren",        ren_out, 0);
    chk("rst.switch_db",  switch_db, 0);
    chk("rst.bank_sel",   bank_sel, 0);
    chk("rst.busy",       busy, 0);
    chk("rst.cfg_err",    cfg_err, 0);
    chk("rst.tiles_done", tiles_done, 0);

    // ---------------- vector table: depth=2, reads=3 ----------------
    //              en fl st iv or   ir wen ren sw bank busy err
    tbl[0]  = mk(5'b10111, 7'b0000000, 0); // IDLE, start
    tbl[1]  = mk(5'b10011, 7'b1100010, 0); // PRIME w0
    tbl[2]  = mk(5'b00011, 7'b0000010, 0); // PRIME, disabled
    tbl[3]  = mk(5'b10011, 7'b1100010, 0); // PRIME w1 (last)
    tbl[4]  = mk(5'b00011, 7'b0000010, 0); // SWITCH, disabled: no strobe
    tbl[5]  = mk(5'b10011, 7'b0001010, 0); // SWITCH
    tbl[6]  = mk(5'b10011, 7'b1110110, 0); // RUN w0 r0
    tbl[7]  = mk(5'b10011, 7'b1110110, 0); // RUN w1 (last) r1
    tbl[8]  = mk(5'b10011, 7'b0010110, 0); // HOLD_W r2 (last)
    tbl[9]  = mk(5'b10011, 7'b0001110, 0); // SWITCH, tile counted
    tbl[10] = mk(5'b10001, 7'b1010010, 1); // RUN, producer idle, r0
    tbl[11] = mk(5'b10001, 7'b1010010, 1); // RUN r1
    tbl[12] = mk(5'b10001, 7'b1010010, 1); // RUN r2 (last)
    tbl[13] = mk(5'b10011, 7'b1100010, 1); // HOLD_R w0, reads stalled
    tbl[14] = mk(5'b10011, 7'b1100010, 1); // HOLD_R w1 (last)
    tbl[15] = mk(5'b11011, 7'b0000010, 1); // SWITCH with flush: no swap
    tbl[16] = mk(5'b10011, 7'b0000000, 1); // IDLE, bank cleared
    tbl[17] = mk(5'b11111, 7'b0000000, 1); // start with flush: ignored
    tbl[18] = mk(5'b10011, 7'b0000000, 1); // still IDLE
    do_reset();
    cfg_depth = 16'd2; cfg_reads = 32'd3;
    for (int i = 0; i < 19; i++) begin
      clk_en = tbl[i].en; flush = tbl[i].fl; start = tbl[i].st;
      in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
      #3;
      chk($sformatf("row%0d.in_ready", i),   in_ready,   tbl[i].ir);
      chk($sformatf("row%0d.wen", i),        wen_out,    tbl[i].wen);
      chk($sformatf("row%0d.ren", i),        ren_out,    tbl[i].ren);
      chk($sformatf("row%0d.switch_db", i),  switch_db,  tbl[i].sw);
      chk($sformatf("row%0d.bank_sel", i),   bank_sel,   tbl[i].bank);
      chk($sformatf("row%0d.busy", i),       busy,       tbl[i].bsy);
      chk($sformatf("row%0d.cfg_err", i),    cfg_err,    tbl[i].err);
      chk($sformatf("row%0d.tiles_done", i), tiles_done, tbl[i].tiles);
      next_cycle();
    end
    flush = 1'b0; start = 1'b0;

    // ---------------- streaming tile, plain and clk_en-stretched ----------
    scen_basic(1);
    scen_basic(2);

    // ---------------- depth=4, reads=4: SWITCH every 5 cycles -------------
    do_reset();
    cfg_depth = 16'd4; cfg_reads = 32'd4; in_valid = 1'b1; out_ready = 1'b1;
    clk_en = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      start = (c == 1);
      #3;
      if (switch_db) begin
        sw_cyc.push_back(c);
        sw_bank.push_back(int'(bank_sel));
      end
      next_cycle();
    end
    start = 1'b0;
    exp_cyc  = '{6, 11, 16, 21};
    exp_bank = '{0, 1, 0, 1};
    chk("pp.n_switch", sw_cyc.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("pp.switch%0d_cyc", k),  (k < sw_cyc.size())  ? sw_cyc[k]  : -1, exp_cyc[k]);
      chk($sformatf("pp.switch%0d_bank", k), (k < sw_bank.size()) ? sw_bank[k] : -1, exp_bank[k]);
    end
    chk("pp.tiles_done", tiles_done, 3);

    // ---------------- read back-pressure: out_ready low for 10 cycles -----
    do_reset();
    sw_cyc.delete();
    cfg_depth = 16'd4; cfg_reads = 32'd16; in_valid = 1'b1;
    clk_en = 1'b1;
    wen_mid = 0; ren_mid = 0; ir_hold = -1;
    for (int c = 1; c <= 35; c++) begin
      start     = (c == 1);
      out_ready = !(c >= 7 && c <= 16);
      #3;
      if (sw_cyc.size() == 1) begin
        wen_mid += int'(wen_out);
        ren_mid += int'(ren_out);
      end
      if (c == 12) ir_hold = int'(in_ready);
      if (switch_db) sw_cyc.push_back(c);
      next_cycle();
    end
    start = 1'b0;
    chk("bp.n_switch",    sw_cyc.size(), 2);
    chk("bp.switch1_cyc", (sw_cyc.size() > 0) ? sw_cyc[0] : -1, 6);
    chk("bp.switch2_cyc", (sw_cyc.size() > 1) ? sw_cyc[1] : -1, 33);
    chk("bp.in_ready_holdw", ir_hold, 0);
    chk("bp.wen_tile",    wen_mid, 4);
    chk("bp.ren_tile",    ren_mid, 16);

    // ---------------- flush with wcnt=2 in RUN, after two drained tiles ---
    do_reset();
    cfg_depth = 16'd3; cfg_reads = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
    clk_en = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      start = (c == 1);
      flush = (c == 16);
      #3;
      if (c == 16) begin
        chk("fl.wen_at_flush",      wen_out, 0);
        chk("fl.ren_at_flush",      ren_out, 0);
        chk("fl.in_ready_at_flush", in_ready, 0);
        chk("fl.bank_before",       bank_sel, 1);
        chk("fl.tiles_before",      tiles_done, 2);
      end
      next_cycle();
    end
    start = 1'b0; flush = 1'b0;
    #3;
    chk("fl.busy_after",  busy, 0);
    chk("fl.bank_after",  bank_sel, 0);
    chk("fl.tiles_after", tiles_done, 2);
    chk("fl.err_after",   cfg_err, 0);
    ir_idle = 0;
    for (int c = 0; c < 4; c++) begin
      #3;
      ir_idle += int'(in_ready) + int'(wen_out);
      next_cycle();
    end
    chk("fl.in_ready_idle", ir_idle, 0);

    // ---------------- asynchronous reset mid-tile with clk_en=0 -----------
    do_reset();
    cfg_depth = 16'd4; cfg_reads = 32'd16; in_valid = 1'b1; out_ready = 1'b1;
    clk_en = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      start = (c == 1);
      next_cycle();
    end
    start = 1'b0;
    #1;
    chk("ar.busy_before", busy, 1);
    chk("ar.bank_before", bank_sel, 1);
    clk_en = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("ar.busy",     busy, 0);
    chk("ar.bank_sel", bank_sel, 0);
    chk("ar.in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ---------------- configuration errors ----------------
    do_reset();
    clk_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cfg_depth = 16'd0; cfg_reads = 32'd4; start = 1'b1;
    next_cycle();
    start = 1'b0;
    #3;
    chk("ce.err_depth0",  cfg_err, 1);
    chk("ce.busy_depth0", busy, 0);
    chk("ce.ir_depth0",   in_ready, 0);
    next_cycle();
    cfg_depth = 16'd4; cfg_reads = 32'd0; start = 1'b1;
    next_cycle();
    start = 1'b0; flush = 1'b1;
    #3;
    chk("ce.err_reads0",  cfg_err, 1);
    chk("ce.busy_reads0", busy, 0);
    next_cycle();
    flush = 1'b0;
    #3;
    chk("ce.err_held_by_flush", cfg_err, 1);
    next_cycle();
    cfg_depth = 16'd4; cfg_reads = 32'd4; start = 1'b1;
    next_cycle();
    start = 1'b0;
    #3;
    chk("ce.err_cleared", cfg_err, 0);
    chk("ce.busy_prime",  busy, 1);
    chk("ce.ir_prime",    in_ready, 1);
    s = 0;
    for (int c = 0; c < 6; c++) begin
      #3;
      s += int'(switch_db);
      next_cycle();
    end
    chk("ce.prime_switch", s, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the bench never hangs.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule
